// File: rtl/modifying_adder_seq.sv
// Triplet sequencer for the three-operand complex adder: o1 = i1 + i3, o2 = i1 + i2,
// emitted as a two-beat valid/ready stream with frame-last marking and sticky overflow.
module modifying_adder_seq #(
  parameter int bit_width = 16,
  parameter bit SAT       = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [bit_width-1:0] Re_in,
  input  logic signed [bit_width-1:0] Im_in,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [bit_width-1:0] Re_out,
  output logic signed [bit_width-1:0] Im_out,
  output logic                        out_sel,
  output logic                        out_last,
  output logic                        ovf
);
  localparam int W = bit_width;

  typedef enum logic [2:0] {
    LD1  = 3'd0,
    LD2  = 3'd1,
    LD3  = 3'd2,
    FIRE = 3'd3,
    OUT1 = 3'd4,
    OUT2 = 3'd5
  } state_t;

  // Complex operand packed as {re, im}
  typedef logic [2*W-1:0] cplx_t;

  function automatic logic [W:0] ext_add(input logic [W-1:0] a, input logic [W-1:0] b);
    return {a[W-1], a} + {b[W-1], b};
  endfunction

  function automatic logic sum_ovf(input logic [W:0] s);
    return s[W] ^ s[W-1];
  endfunction

  function automatic logic [W-1:0] fit(input logic [W:0] s);
    logic [W-1:0] res;
    if (SAT && sum_ovf(s)) begin
      res = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      res = s[W-1:0];
    end
    return res;
  endfunction

  state_t       state_q, state_d;
  cplx_t        op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
  cplx_t        r1_q, r1_d, r2_q, r2_d;
  logic         last_pend_q, last_pend_d;
  logic         ovf_arm_q, ovf_arm_d;
  logic         ovf_q, ovf_d;
  logic         out_valid_q, out_valid_d;
  logic         out_sel_q, out_sel_d;
  logic         out_last_q, out_last_d;
  logic [W-1:0] re_out_q, re_out_d, im_out_q, im_out_d;

  logic         accept_s;
  logic         fire_ovf_s;
  logic [W:0]   s1_re_s, s1_im_s, s2_re_s, s2_im_s;

  assign in_ready = ~rst & ((state_q == LD1) | (state_q == LD2) | (state_q == LD3));
  assign accept_s = in_valid & in_ready;

  assign s1_re_s = ext_add(op1_q[2*W-1:W], op3_q[2*W-1:W]);
  assign s1_im_s = ext_add(op1_q[W-1:0],   op3_q[W-1:0]);
  assign s2_re_s = ext_add(op1_q[2*W-1:W], op2_q[2*W-1:W]);
  assign s2_im_s = ext_add(op1_q[W-1:0],   op2_q[W-1:0]);
  assign fire_ovf_s = sum_ovf(s1_re_s) | sum_ovf(s1_im_s) | sum_ovf(s2_re_s) | sum_ovf(s2_im_s);

  assign out_valid = out_valid_q;
  assign Re_out    = re_out_q;
  assign Im_out    = im_out_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    op3_d       = op3_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    last_pend_d = last_pend_q;
    ovf_arm_d   = ovf_arm_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    re_out_d    = re_out_q;
    im_out_d    = im_out_q;

    case (state_q)
      LD1: begin
        if (accept_s) begin
          op1_d = {Re_in, Im_in};
          // First accept after a frame-last handshake opens a new overflow window
          if (ovf_arm_q) begin
            ovf_d     = 1'b0;
            ovf_arm_d = 1'b0;
          end else begin
            ovf_d = ovf_q;
          end
          if (in_last) begin
            op2_d       = '0;
            op3_d       = '0;
            last_pend_d = 1'b1;
            state_d     = FIRE;
          end else begin
            state_d = LD2;
          end
        end else begin
          state_d = LD1;
        end
      end
      LD2: begin
        if (accept_s) begin
          op2_d = {Re_in, Im_in};
          if (in_last) begin
            op3_d       = '0;
            last_pend_d = 1'b1;
            state_d     = FIRE;
          end else begin
            state_d = LD3;
          end
        end else begin
          state_d = LD2;
        end
      end
      LD3: begin
        if (accept_s) begin
          op3_d       = {Re_in, Im_in};
          last_pend_d = in_last;
          state_d     = FIRE;
        end else begin
          state_d = LD3;
        end
      end
      FIRE: begin
        r1_d        = {fit(s1_re_s), fit(s1_im_s)};
        r2_d        = {fit(s2_re_s), fit(s2_im_s)};
        ovf_d       = ovf_q | fire_ovf_s;
        out_valid_d = 1'b1;
        re_out_d    = fit(s1_re_s);
        im_out_d    = fit(s1_im_s);
        out_sel_d   = 1'b0;
        out_last_d  = 1'b0;
        state_d     = OUT1;
      end
      OUT1: begin
        if (out_ready) begin
          re_out_d   = r2_q[2*W-1:W];
          im_out_d   = r2_q[W-1:0];
          out_sel_d  = 1'b1;
          out_last_d = last_pend_q;
          state_d    = OUT2;
        end else begin
          state_d = OUT1;
        end
      end
      OUT2: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          re_out_d    = '0;
          im_out_d    = '0;
          out_sel_d   = 1'b0;
          out_last_d  = 1'b0;
          state_d     = LD1;
          if (last_pend_q) begin
            last_pend_d = 1'b0;
            ovf_arm_d   = 1'b1;
          end else begin
            last_pend_d = last_pend_q;
          end
        end else begin
          state_d = OUT2;
        end
      end
      default: begin
        state_d = LD1;
      end
    endcase
  end

  // Single state/output register bank; reset discards any partial triplet or pending beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LD1;
      op1_q       <= '0;
      op2_q       <= '0;
      op3_q       <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      last_pend_q <= 1'b0;
      ovf_arm_q   <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sel_q   <= 1'b0;
      out_last_q  <= 1'b0;
      re_out_q    <= '0;
      im_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      op3_q       <= op3_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      last_pend_q <= last_pend_d;
      ovf_arm_q   <= ovf_arm_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      re_out_q    <= re_out_d;
      im_out_q    <= im_out_d;
    end
  end

endmodule

// File: tb/tb_modifying_adder_seq.sv
// Directed bench for modifying_adder_seq: a wrapping and a saturating instance share stimulus.
module tb_modifying_adder_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic signed [15:0] Re_in = 16'sd0;
  logic signed [15:0] Im_in = 16'sd0;

  logic in_ready0, in_ready1, out_valid0, out_valid1;
  logic out_sel0, out_sel1, out_last0, out_last1, ovf0, ovf1;
  logic signed [15:0] re0, im0, re1, im1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  modifying_adder_seq #(.bit_width(16), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .Re_in(Re_in), .Im_in(Im_in), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready), .Re_out(re0), .Im_out(im0),
    .out_sel(out_sel0), .out_last(out_last0), .ovf(ovf0)
  );

  modifying_adder_seq #(.bit_width(16), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .Re_in(Re_in), .Im_in(Im_in), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready), .Re_out(re1), .Im_out(im1),
    .out_sel(out_sel1), .out_last(out_last1), .ovf(ovf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic put(input int re, input int im, input logic last);
    in_valid = 1'b1;
    Re_in    = 16'(re);
    Im_in    = 16'(im);
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int d, input int v, input int re, input int im,
                         input int sel, input int last);
    if (d == 0) begin
      chk({tag, ".wrap.valid"}, out_valid0, v);
      chk({tag, ".wrap.re"}, re0, re);
      chk({tag, ".wrap.im"}, im0, im);
      chk({tag, ".wrap.sel"}, out_sel0, sel);
      chk({tag, ".wrap.last"}, out_last0, last);
    end else begin
      chk({tag, ".sat.valid"}, out_valid1, v);
      chk({tag, ".sat.re"}, re1, re);
      chk({tag, ".sat.im"}, im1, im);
      chk({tag, ".sat.sel"}, out_sel1, sel);
      chk({tag, ".sat.last"}, out_last1, last);
    end
  endtask

  task automatic chk_both(input string tag, input int v, input int re, input int im,
                          input int sel, input int last);
    chk_out(tag, 0, v, re, im, sel, last);
    chk_out(tag, 1, v, re, im, sel, last);
  endtask

  task automatic chk_ovf(input string tag, input int e);
    chk({tag, ".wrap.ovf"}, ovf0, e);
    chk({tag, ".sat.ovf"}, ovf1, e);
  endtask

  task automatic chk_rdy(input string tag, input int e);
    chk({tag, ".wrap.in_ready"}, in_ready0, e);
    chk({tag, ".sat.in_ready"}, in_ready1, e);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk_rdy("reset", 0);
    chk_both("reset", 0, 0, 0, 0, 0);
    chk_ovf("reset", 0);
    rst = 1'b0;
    #1;
    chk_rdy("after_reset", 1);

    // Basic triplet with downstream always ready
    out_ready = 1'b1;
    put(100, -50, 1'b0);
    put(20, 5, 1'b0);
    put(-30, 7, 1'b0);
    chk_rdy("basic_fire", 0);
    chk_both("basic_fire", 0, 0, 0, 0, 0);
    tick();
    chk_both("basic_o1", 1, 70, -43, 0, 0);
    tick();
    chk_both("basic_o2", 1, 120, -45, 1, 0);
    chk_ovf("basic", 0);
    tick();
    chk_both("basic_idle", 0, 0, 0, 0, 0);
    chk_rdy("basic_idle", 1);

    // Backpressure on both beats
    out_ready = 1'b0;
    put(100, -50, 1'b0);
    put(20, 5, 1'b0);
    put(-30, 7, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_both("bp_o1_hold", 1, 70, -43, 0, 0);
      chk_rdy("bp_o1_hold", 0);
      tick();
    end
    out_ready = 1'b1;
    chk_both("bp_o1_hs", 1, 70, -43, 0, 0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_both("bp_o2_hold", 1, 120, -45, 1, 0);
      chk_rdy("bp_o2_hold", 0);
      tick();
    end
    out_ready = 1'b1;
    chk_both("bp_o2_hs", 1, 120, -45, 1, 0);
    tick();
    chk_both("bp_done", 0, 0, 0, 0, 0);

    // Frame A: overflowing triplet, then a lone final sample
    put(32767, -32768, 1'b0);
    put(0, 0, 1'b0);
    put(1, -1, 1'b0);
    tick();
    chk_out("wrap_o1", 0, 1, -32768, 32767, 0, 0);
    chk_out("sat_o1", 1, 1, 32767, -32768, 0, 0);
    chk_ovf("ws_o1", 1);
    tick();
    chk_both("ws_o2", 1, 32767, -32768, 1, 0);
    tick();
    put(5, 6, 1'b1);
    chk_rdy("short_fire", 0);
    tick();
    chk_both("short_o1", 1, 5, 6, 0, 0);
    tick();
    chk_both("short_o2", 1, 5, 6, 1, 1);
    tick();
    chk_ovf("after_a_last", 1);
    chk_both("after_a_last", 0, 0, 0, 0, 0);

    // Frame B: clean, ovf drops on its first accept
    put(1, 1, 1'b0);
    chk_ovf("b_first_accept", 0);
    put(2, 2, 1'b0);
    put(3, 3, 1'b1);
    tick();
    chk_both("b_o1", 1, 4, 4, 0, 0);
    tick();
    chk_both("b_o2", 1, 3, 3, 1, 1);
    chk_ovf("b_o2", 0);
    tick();

    // Reset while waiting in LD3
    put(9, 9, 1'b0);
    put(8, 8, 1'b0);
    chk_rdy("ld3_before_rst", 1);
    rst = 1'b1;
    tick();
    chk_both("rst_ld3", 0, 0, 0, 0, 0);
    chk_rdy("rst_ld3", 0);
    rst = 1'b0;
    put(10, 1, 1'b0);
    put(20, 2, 1'b0);
    put(30, 3, 1'b0);
    tick();
    chk_both("post_rst_ld3_o1", 1, 40, 4, 0, 0);
    tick();
    chk_both("post_rst_ld3_o2", 1, 30, 3, 1, 0);
    tick();

    // Reset while stalled in OUT1 with overflow recorded
    out_ready = 1'b0;
    put(32767, 0, 1'b0);
    put(0, 0, 1'b0);
    put(1, 0, 1'b0);
    tick();
    chk_ovf("out1_before_rst", 1);
    rst = 1'b1;
    tick();
    chk_both("rst_out1", 0, 0, 0, 0, 0);
    chk_ovf("rst_out1", 0);
    rst = 1'b0;
    out_ready = 1'b1;
    put(-1, -2, 1'b0);
    put(-3, -4, 1'b0);
    put(-5, -6, 1'b0);
    tick();
    chk_both("post_rst_out1_o1", 1, -6, -8, 0, 0);
    tick();
    chk_both("post_rst_out1_o2", 1, -4, -6, 1, 0);
    chk_ovf("post_rst_out1", 0);
    tick();
    chk_both("final_idle", 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
